popcnt_arbiter: RTL and testbench
=================================

# popcnt_arbiter

Round-robin arbiter that shares one `num_ones` population-count datapath among `NREQ` requesters. Each requester presents a `WIDTH`-bit word with a valid/ready handshake. The block grants at most one word per cycle, counts its set bits, and returns the count with the requester ID through a single-entry registered output stage. It sits between the requesting units and the shared bit-count resource, so that only one `num_ones` instance exists.

## Interface
- `WIDTH`, default 16: data word width; passed to the internal `num_ones #(.WIDTH(WIDTH))`.
- `NREQ`, default 4: number of requesters; legal range 2..8.
- Derived: `ONES_W = $clog2(WIDTH+1)` (5 at default); `ID_W = $clog2(NREQ)` (2 at default).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i has a word pending.
- `req_data`  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- `res_valid`  out  1  result register holds a valid count.
- `res_ready`  in  1  consumer accepts the result this cycle.
- `res_ones`  out  ONES_W  number of 1 bits in the granted word.
- `res_id`  out  ID_W  index of the requester whose word produced `res_ones`.

## Operation
- Output stage FSM, 2 states:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- The stage can take a new result ("can_load") when it is EMPTY, or when it is FULL and `res_ready`=1 in the same cycle. This gives pass-through drain and refill.
- Arbitration (combinational), evaluated only when can_load=1:
  - Scan from `ptr` upward, modulo NREQ.
  - The first i with `req_valid[i]`=1 wins; `req_ready[i]`=1.
  - If can_load=0 or no requests are valid, `req_ready` is all zero.
- The grant mux drives the winner's word into `num_ones`.
- On a grant at the clock edge:
  - `res_ones` <= popcount.
  - `res_id` <= i.
  - State goes to FULL.
  - `ptr` <= (i+1) mod NREQ.
- FULL with `res_ready`=1 and no grant: go to EMPTY; `res_ones`/`res_id` hold their last values.
- FULL with `res_ready`=0: state, `res_ones` and `res_id` hold; no grant.
- `ptr` changes only on a grant.
- A requester continuously requesting waits at most NREQ-1 grants (starvation-free).
- `req_data` of non-granted requesters is ignored. A requester may change data or drop valid before it is granted.
- Count range is 0..WIDTH. All-ones gives WIDTH, which must fit in ONES_W bits with no wrap.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State EMPTY, `res_valid`=0, `res_ones`=0, `res_id`=0, `ptr`=0.
  - `req_ready`=0 while `rst_n`=0.
- Reset mid-operation discards any held result immediately. The first grant after release starts from requester 0.
- Latency: a word accepted at edge N (`req_ready`&`req_valid` high before edge N) appears on `res_*` with `res_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 result/cycle while `res_ready` is held at 1.
- Backpressure: `res_ready`=0 while FULL stalls all grants. `req_ready` is combinationally dependent on `res_ready` and `req_valid` (no registered ready).
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and `res_valid` stays 1 with no bubble.

## Test plan
- Reset/idle:
  - Assert `rst_n`=0 mid-transfer with the output FULL -> `res_valid`=0, `res_ones`=0, `res_id`=0 immediately.
  - After release with no requests -> `req_ready`=0, `res_valid` stays 0.
- Single requester, `res_ready`=1:
  - req1 streams 16'hFFFF, 16'hF56F, 16'h3FFF, 16'h0001 on consecutive cycles -> one cycle later, one per cycle: `res_ones`=16,12,14,1 with `res_id`=1, and `res_valid` continuously 1.
- Round-robin:
  - All 4 requesters valid every cycle (req0=16'hF10F, req1=16'h7822, req2=16'h7ABC, req3=16'h0000), `res_ready`=1 -> grant order 0,1,2,3,0,…
  - Results: (9,id0), (6,id1), (10,id2), (0,id3), repeating.
- Pointer continuation:
  - req2 granted alone; then req0 and req3 request together -> req3 is granted first, then req0.
- Backpressure:
  - Result (12,id0) held with `res_ready`=0 for 3 cycles while req1 is valid -> `req_ready`=0, outputs stable.
  - First cycle `res_ready`=1 -> req1 is granted that same cycle, and the next cycle shows req1's count with no `res_valid` gap.
- Boundary counts:
  - 16'h0000 gives 0 and 16'hFFFF gives 16 (no 5-bit wrap).
  - With WIDTH=8 rerun: 8'hFF gives 8 with ONES_W=4.

Source files
------------

// File: rtl/popcnt_arbiter_if.sv
// Requester/consumer bundle for popcnt_arbiter: NREQ valid/ready word inputs and one
// registered count result with its requester ID.
interface popcnt_arbiter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4
);
   localparam int unsigned ONES_W = $clog2(WIDTH + 1);
   localparam int unsigned ID_W   = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic                  res_ready;
   logic [ONES_W-1:0]     res_ones;
   logic [ID_W-1:0]       res_id;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_ones, res_id
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_ones, res_id
   );
endinterface

// File: rtl/num_ones.sv
// Combinational population count of a WIDTH-bit word; result range 0..WIDTH.
module num_ones #(
   parameter int unsigned WIDTH = 16,
   localparam int unsigned ONES_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]  data_i,
   output logic [ONES_W-1:0] ones_o
);
   always_comb begin
      ones_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones_o = ones_o + ONES_W'(data_i[i]);
      end
   end
endmodule

// File: rtl/popcnt_arbiter.sv
// Round-robin arbiter sharing one num_ones datapath among NREQ requesters, with a
// single-entry registered result stage that drains and refills in the same cycle.
module popcnt_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4
) (
   input logic             clk,
   input logic             rst_n,
   popcnt_arbiter_if.slave bus
);
   localparam int unsigned ONES_W = $clog2(WIDTH + 1);
   localparam int unsigned ID_W   = $clog2(NREQ);

   localparam logic StEmpty = 1'b0;
   localparam logic StFull  = 1'b1;

   logic              state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [ID_W-1:0]   id_q, id_d;

   logic              can_load;
   logic [NREQ-1:0]   grant;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [WIDTH-1:0]  gnt_data;
   logic [ONES_W-1:0] gnt_ones;
   logic [WIDTH-1:0]  words [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_words
      assign words[g] = bus.req_data[g*WIDTH +: WIDTH];
   end

   // A full stage frees up in the same cycle the consumer takes it.
   assign can_load = (state_q == StEmpty) || bus.res_ready;

   always_comb begin
      logic [ID_W-1:0] idx;
      idx       = '0;
      grant     = '0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      if (can_load) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[idx]) begin
               gnt_found  = 1'b1;
               grant[idx] = 1'b1;
               gnt_id     = idx;
            end
         end
      end
   end

   assign gnt_data = words[gnt_id];

   num_ones #(
      .WIDTH (WIDTH)
   ) u_num_ones (
      .data_i (gnt_data),
      .ones_o (gnt_ones)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ones_d  = ones_q;
      id_d    = id_q;
      if (gnt_found) begin
         state_d = StFull;
         ones_d  = gnt_ones;
         id_d    = gnt_id;
         ptr_d   = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end else if (state_q == StFull && bus.res_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         ptr_q   <= '0;
         ones_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ones_q  <= ones_d;
         id_q    <= id_d;
      end
   end

   // Reset leaves the stage EMPTY, so ready must be masked explicitly while held.
   assign bus.req_ready = grant & {NREQ{rst_n}};
   assign bus.res_valid = (state_q == StFull);
   assign bus.res_ones  = ones_q;
   assign bus.res_id    = id_q;
endmodule

// File: tb/tb_popcnt_arbiter.sv
// Directed self-checking bench for popcnt_arbiter (WIDTH=16/NREQ=4 plus a WIDTH=8 instance).
module tb_popcnt_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   popcnt_arbiter_if #(.WIDTH(16), .NREQ(4)) bus ();
   popcnt_arbiter_if #(.WIDTH(8),  .NREQ(2)) bus8 ();

   popcnt_arbiter #(.WIDTH(16), .NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   popcnt_arbiter #(.WIDTH(8), .NREQ(2)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int i, input logic [15:0] w);
      bus.req_data[i*16 +: 16] = w;
   endtask

   task automatic check_res(input string tag, input int ones, input int id);
      check({tag, "_valid"}, 32'(bus.res_valid), 1);
      check({tag, "_ones"}, 32'(bus.res_ones), ones);
      check({tag, "_id"}, 32'(bus.res_id), id);
   endtask

   logic [15:0] stream_w [4] = '{16'hFFFF, 16'hF56F, 16'h3FFF, 16'h0001};
   int          stream_n [4] = '{16, 12, 14, 1};
   logic [15:0] rr_w     [4] = '{16'hF10F, 16'h7822, 16'h7ABC, 16'h0000};
   int          rr_n     [4] = '{9, 6, 10, 0};

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 4'hF;
      bus.req_data   = '0;
      bus.res_ready  = 1'b1;
      bus8.req_valid = '0;
      bus8.req_data  = '0;
      bus8.res_ready = 1'b1;
      #3;
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_valid", 32'(bus.res_valid), 0);
      check("rst_ones", 32'(bus.res_ones), 0);
      check("rst_id", 32'(bus.res_id), 0);

      @(negedge clk);
      rst_n         = 1'b1;
      bus.req_valid = '0;
      #1;
      check("idle_ready", 32'(bus.req_ready), 0);
      step();
      check("idle_valid", 32'(bus.res_valid), 0);

      // Single requester streaming one word per cycle.
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         set_word(1, stream_w[k]);
         #1;
         check("stream_ready", 32'(bus.req_ready), 32'h2);
         step();
         check_res("stream", stream_n[k], 1);
      end
      bus.req_valid = '0;
      bus.res_ready = 1'b0;
      step();
      check_res("hold", 1, 1);

      // Asynchronous reset while FULL.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.res_valid), 0);
      check("midrst_ones", 32'(bus.res_ones), 0);
      check("midrst_id", 32'(bus.res_id), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin with all four requesters; must start from requester 0.
      for (int i = 0; i < 4; i++) set_word(i, rr_w[i]);
      bus.req_valid = 4'hF;
      bus.res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
         step();
         check_res("rr", rr_n[k % 4], k % 4);
      end

      // Pointer continuation: after req2, req3 goes before req0.
      bus.req_valid = 4'b0100;
      #1;
      step();
      check_res("ptr_r2", 10, 2);
      bus.req_valid = 4'b1001;
      #1;
      check("ptr_ready_a", 32'(bus.req_ready), 32'h8);
      step();
      check_res("ptr_r3", 0, 3);
      check("ptr_ready_b", 32'(bus.req_ready), 32'h1);
      step();
      check_res("ptr_r0", 9, 0);

      // Backpressure: hold (12,id0) for three cycles with req1 pending.
      set_word(0, 16'hF56F);
      bus.req_valid = 4'b0001;
      #1;
      check("bp_ready0", 32'(bus.req_ready), 32'h1);
      step();
      check_res("bp_load", 12, 0);
      bus.res_ready = 1'b0;
      set_word(1, 16'h3FFF);
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_stall_ready", 32'(bus.req_ready), 0);
         step();
         check_res("bp_stall", 12, 0);
      end
      bus.res_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.req_ready), 32'h2);
      step();
      check_res("bp_refill", 14, 1);
      bus.req_valid = '0;
      step();
      check("drain_valid", 32'(bus.res_valid), 0);
      check("drain_id_hold", 32'(bus.res_id), 1);

      // Zero count on the 16-bit instance.
      set_word(2, 16'h0000);
      bus.req_valid = 4'b0100;
      step();
      check_res("zero", 0, 2);
      bus.req_valid = '0;

      // WIDTH=8 instance: all-ones must give 8 in 4 bits.
      bus8.req_data  = {8'hFF, 8'h00};
      bus8.req_valid = 2'b10;
      #1;
      check("w8_ready", 32'(bus8.req_ready), 32'h2);
      step();
      check("w8_valid", 32'(bus8.res_valid), 1);
      check("w8_ones", 32'(bus8.res_ones), 8);
      check("w8_id", 32'(bus8.res_id), 1);
      bus8.req_valid = 2'b01;
      step();
      check("w8_zero_ones", 32'(bus8.res_ones), 0);
      check("w8_zero_id", 32'(bus8.res_id), 0);
      bus8.req_valid = '0;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
